// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; the master modport drives the requesters and the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port.
// Macro ARB_RR_EN selects round-robin tie-breaking; undefined gives data-first priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_arbiter_if.slave     bus,
  output logic             stall,
  output logic [CNT_W-1:0] conflict_cnt
);
  // state  | meaning
  // IDLE   | no transaction, sampling i_req/d_req
  // BUSY_I | fetch on memory port, waiting for m_ack
  // BUSY_D | load/store on memory port, waiting for m_ack
  // RESP_I | one-cycle i_ack
  // RESP_D | one-cycle d_ack
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} stateT;

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] mAddr;
  logic              mWe;
  logic [DATA_W-1:0] mWdata;
  logic [DATA_W-1:0] iRdata;
  logic [DATA_W-1:0] dRdata;
  logic              iAck;
  logic              dAck;
  logic              tie;
  logic              grantD;

  assign tie = bus.i_req & bus.d_req;

`ifdef ARB_RR_EN
  logic lastGrantD;

  assign grantD = bus.d_req & (~bus.i_req | ~lastGrantD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lastGrantD <= 1'b0;
    else if (state == IDLE && (bus.i_req | bus.d_req))
      lastGrantD <= grantD;
  end
`else
  assign grantD = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (grantD)
          stateNext = BUSY_D;
        else if (bus.i_req)
          stateNext = BUSY_I;
      end
      BUSY_I:  if (bus.m_ack) stateNext = RESP_I;
      BUSY_D:  if (bus.m_ack) stateNext = RESP_D;
      RESP_I:  stateNext = IDLE;
      RESP_D:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Memory-port fields are latched on grant so requesters may change or drop their inputs mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mAddr  <= '0;
      mWe    <= 1'b0;
      mWdata <= '0;
      iRdata <= '0;
      dRdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantD) begin
            mAddr  <= bus.d_addr;
            mWe    <= bus.d_we;
            mWdata <= bus.d_wdata;
          end else if (bus.i_req) begin
            mAddr <= bus.i_addr;
            mWe   <= 1'b0;
          end
        end
        BUSY_I:  if (bus.m_ack) iRdata <= bus.m_rdata;
        BUSY_D:  if (bus.m_ack && !mWe) dRdata <= bus.m_rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (state == IDLE && tie && !(&conflict_cnt))
      conflict_cnt <= conflict_cnt + CNT_W'(1);
  end

  assign iAck        = (state == RESP_I);
  assign dAck        = (state == RESP_D);
  assign bus.i_ack   = iAck;
  assign bus.d_ack   = dAck;
  assign bus.i_rdata = iRdata;
  assign bus.d_rdata = dRdata;
  assign bus.m_req   = (state == BUSY_I) || (state == BUSY_D);
  assign bus.m_we    = mWe;
  assign bus.m_addr  = mAddr;
  assign bus.m_wdata = mWdata;
  assign stall       = (bus.i_req & ~iAck) | (bus.d_req & ~dAck);
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width of all address ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width of all data ports.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning conflict counter width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_req  input  1  instruction-fetch request (level, held until i_ack); i_addr  input  ADDR_W  fetch address.
REQ-007 i_ack  output  1  one-cycle fetch completion; i_rdata  output  DATA_W  fetched word, valid while i_ack=1.
REQ-008 d_req  input  1  data request (level, held until d_ack); d_we  input  1  1=store, 0=load; d_addr  input  ADDR_W; d_wdata  input  DATA_W.
REQ-009 d_ack  output  1  one-cycle data completion; d_rdata  output  DATA_W  load word, valid while d_ack=1 after a load.
REQ-010 m_req, m_we  output  1 each; m_addr  output  ADDR_W; m_wdata  output  DATA_W  shared memory port, held stable until m_ack.
REQ-011 m_ack  input  1  memory completion; m_rdata  input  DATA_W  valid when m_ack=1.
REQ-012 stall  output  1  pipeline hold to PC/pipeline registers; conflict_cnt  output  CNT_W  tie-arbitration counter.

Function
REQ-013 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D, held in a registered state variable.
REQ-014 IDLE: d_req=1 (granted per REQ-021/REQ-029) -> BUSY_D; else i_req=1 -> BUSY_I; else stay IDLE.
REQ-015 On entry to BUSY_x, m_addr/m_we/m_wdata SHALL be loaded into registers from the granted requester (m_we=0, m_wdata unchanged for fetches), and m_req SHALL be 1 from the first BUSY cycle.
REQ-016 BUSY_x SHALL hold m_req=1 and all m_* outputs constant until a cycle with m_ack=1, then go to RESP_x, capturing m_rdata into i_rdata (BUSY_I) or into d_rdata (BUSY_D with m_we=0).
REQ-017 RESP_x SHALL assert i_ack (RESP_I) or d_ack (RESP_D) for exactly one cycle, m_req=0, then return to IDLE.
REQ-018 Minimum latency: request seen in IDLE at cycle 0, m_req=1 at cycle 1, m_ack at cycle 1 -> ack at cycle 2; next request is sampled in IDLE at cycle 3.
REQ-019 d_rdata SHALL NOT change on store completion; i_rdata/d_rdata SHALL otherwise hold their last captured value.
REQ-020 m_ack in IDLE or RESP_x SHALL be ignored; i_ack and d_ack SHALL never be 1 in the same cycle.
REQ-021 Without ARB_RR_EN, simultaneous i_req=1 and d_req=1 in IDLE SHALL grant the data port (fixed priority).
REQ-022 stall SHALL equal (i_req & ~i_ack) | (d_req & ~d_ack), combinationally.
REQ-023 conflict_cnt SHALL increment by 1 in each IDLE cycle with i_req=1 and d_req=1, saturating at 2^CNT_W-1 (no wrap).
REQ-024 A requester deasserting req while in BUSY_x SHALL NOT abort the memory transaction; the ack is still issued.

Reset
REQ-025 While rst_n=0, independent of clk: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, conflict_cnt=0, last-grant register=I.
REQ-026 Reset asserted in BUSY_x SHALL drop m_req immediately and abandon the transaction; no ack SHALL follow after reset release.
REQ-027 Reset release SHALL take effect on the first rising clk edge with rst_n=1.

Configuration
REQ-028 Macro ARB_RR_EN SHALL select the tie-break policy.
REQ-029 With ARB_RR_EN defined: a last-grant register SHALL update on every grant; on a tie, the requester not last granted wins (first tie after reset goes to D); single requests are granted as in REQ-014.
REQ-030 Without ARB_RR_EN: no last-grant register SHALL be built, and REQ-021 applies.

Verification
REQ-031 Fetch only: i_req=1, i_addr=0x40, m_ack=1 in first BUSY cycle with m_rdata=0x8C220004 -> m_req at cycle 1, i_ack=1 and i_rdata=0x8C220004 at cycle 2, stall=0 at cycle 2.
REQ-032 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, m_ack after 3 BUSY cycles -> m_* stable for 3 cycles, m_we=1, d_ack one cycle, d_rdata unchanged.
REQ-033 Tie, no macro: i_req=d_req=1 held -> D served first, I next; conflict_cnt=1 after the first IDLE tie cycle.
REQ-034 Tie, ARB_RR_EN: both requests held through 4 transactions -> grant order D, I, D, I.
REQ-035 Reset mid-BUSY_D: rst_n=0 for 1 cycle -> m_req=0 immediately, all outputs at reset values, no d_ack afterwards; conflict_cnt=0.
REQ-036 Saturation: CNT_W=4, 20 tie cycles -> conflict_cnt stops at 15.
